// File: rtl/case_demux_pkg.sv
// Shared types, defaults and helpers for the case_demux block.
package case_demux_pkg;

    typedef enum logic {
        CH_EMPTY = 1'b0,
        CH_FULL  = 1'b1
    } ch_state_e;

    localparam int DEF_N      = 4;
    localparam int DEF_SEL_W  = 2;
    localparam int DEF_DATA_W = 3;
    localparam int DEF_CNT_W  = 4;

    // True when a select code names a real channel; everything else is a drop.
    function automatic logic sel_in_range(input int sel, input int n);
        return (sel >= 0) && (sel < n);
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One output channel: a single-entry holding register with EMPTY/FULL state.
module demux_slot
    import case_demux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fill,
    input  logic              drain,
    input  logic [DATA_W-1:0] word,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    ch_state_e state;

    assign valid = (state == CH_FULL);

    // A fill while FULL only happens when the consumer drains in the same
    // cycle, so the slot stays FULL and simply takes the new word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CH_EMPTY;
            data  <= '0;
        end else begin
            case (state)
                CH_EMPTY: begin
                    if (fill) begin
                        state <= CH_FULL;
                        data  <= word;
                    end
                end
                CH_FULL: begin
                    if (fill)
                        data <= word;
                    else if (drain)
                        state <= CH_EMPTY;
                end
                default: state <= CH_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/case_demux.sv
// Registered 1-to-N demultiplexer with per-channel holding slots and a
// saturating counter for words whose select code names no channel.
module case_demux
    import case_demux_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int SEL_W  = DEF_SEL_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SEL_W-1:0]    in_sel,
    input  logic [DATA_W-1:0]   in_data,
    output logic [N-1:0]        out_valid,
    input  logic [N-1:0]        out_ready,
    output logic [N*DATA_W-1:0] out_data,
    output logic                drop_pulse,
    output logic [CNT_W-1:0]    drop_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [N-1:0] tgt;
    logic [N-1:0] fill;
    logic         drop;
    logic         accept;

    always_comb begin
        tgt = '0;
        for (int i = 0; i < N; i++)
            if (in_sel == SEL_W'(i)) tgt[i] = 1'b1;
        drop = !sel_in_range(int'(in_sel), N);
    end

    // Ready looks only at the addressed slot, so a stalled channel blocks the
    // head of the stream while drops are always taken.
    assign in_ready = drop | (|(tgt & (~out_valid | out_ready)));
    assign accept   = in_valid & in_ready;
    assign fill     = tgt & {N{accept}};

    for (genvar i = 0; i < N; i++) begin : g_slot
        demux_slot #(
            .DATA_W(DATA_W)
        ) u_slot (
            .clk  (clk),
            .reset(reset),
            .fill (fill[i]),
            .drain(out_ready[i]),
            .word (in_data),
            .valid(out_valid[i]),
            .data (out_data[i*DATA_W +: DATA_W])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_pulse <= 1'b0;
            drop_count <= '0;
        end else begin
            drop_pulse <= accept & drop;
            if (accept && drop && drop_count != CNT_MAX)
                drop_count <= drop_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_case_demux.sv
// Directed and scoreboarded checks of case_demux with N=4 and N=3 instances.
module tb_case_demux;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // N=4 instance
    logic        v4 = 1'b0, rdy4;
    logic [1:0]  sel4 = '0;
    logic [2:0]  data4 = '0;
    logic [3:0]  ordy4 = '0, ovld4;
    logic [11:0] odata4;
    logic        dp4;
    logic [3:0]  dc4;

    // N=3 instance: select code 3 is out of range
    logic        v3 = 1'b0, rdy3;
    logic [1:0]  sel3 = '0;
    logic [2:0]  data3 = '0;
    logic [2:0]  ordy3 = '0, ovld3;
    logic [8:0]  odata3;
    logic        dp3;
    logic [3:0]  dc3;

    logic [2:0] sbq [0:2][$];

    case_demux #(.N(4), .SEL_W(2), .DATA_W(3), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(v4), .in_ready(rdy4), .in_sel(sel4),
        .in_data(data4), .out_valid(ovld4), .out_ready(ordy4), .out_data(odata4),
        .drop_pulse(dp4), .drop_count(dc4)
    );

    case_demux #(.N(3), .SEL_W(2), .DATA_W(3), .CNT_W(4)) dut3 (
        .clk(clk), .reset(reset), .in_valid(v3), .in_ready(rdy3), .in_sel(sel3),
        .in_data(data3), .out_valid(ovld3), .out_ready(ordy3), .out_data(odata3),
        .drop_pulse(dp3), .drop_count(dc3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        tests++;
        if (ovld4 !== 4'b0 || odata4 !== 12'b0 || dp4 !== 1'b0 || dc4 !== 4'd0) begin
            fails++;
            $display("FAIL reset4: vld=%b data=%h dp=%b cnt=%0d, want all 0", ovld4, odata4, dp4, dc4);
        end
        tests++;
        if (ovld3 !== 3'b0 || odata3 !== 9'b0 || dp3 !== 1'b0 || dc3 !== 4'd0) begin
            fails++;
            $display("FAIL reset3: vld=%b data=%h dp=%b cnt=%0d, want all 0", ovld3, odata3, dp3, dc3);
        end
    endtask

    task automatic test_stream();
        ordy4 = 4'hF;
        for (int k = 0; k < 4; k++) begin
            v4 = 1'b1; sel4 = 2'(k); data4 = 3'(k);
            #1;
            tests++;
            if (rdy4 !== 1'b1) begin
                fails++;
                $display("FAIL stream_rdy k=%0d: got %b want 1", k, rdy4);
            end
            tick();
            tests++;
            if (ovld4 !== 4'(1 << k) || odata4[k*3 +: 3] !== 3'(k)) begin
                fails++;
                $display("FAIL stream_out k=%0d: vld=%b data=%0d want vld=%b data=%0d",
                         k, ovld4, odata4[k*3 +: 3], 4'(1 << k), k);
            end
        end
        v4 = 1'b0;
        tick();
        tests++;
        if (ovld4 !== 4'b0 || dc4 !== 4'd0) begin
            fails++;
            $display("FAIL stream_end: vld=%b cnt=%0d want 0/0", ovld4, dc4);
        end
    endtask

    task automatic test_stall();
        ordy4 = 4'b1011;
        v4 = 1'b1; sel4 = 2'd2; data4 = 3'd5;
        tick();
        tests++;
        if (ovld4[2] !== 1'b1 || odata4[8:6] !== 3'd5) begin
            fails++;
            $display("FAIL stall_first: vld2=%b data=%0d want 1/5", ovld4[2], odata4[8:6]);
        end
        data4 = 3'd6;
        #1;
        tests++;
        if (rdy4 !== 1'b0) begin
            fails++;
            $display("FAIL stall_rdy: got %b want 0", rdy4);
        end
        tick();
        tests++;
        if (ovld4[2] !== 1'b1 || odata4[8:6] !== 3'd5) begin
            fails++;
            $display("FAIL stall_hold: vld2=%b data=%0d want 1/5", ovld4[2], odata4[8:6]);
        end
        ordy4[2] = 1'b1;
        #1;
        tests++;
        if (rdy4 !== 1'b1) begin
            fails++;
            $display("FAIL stall_release_rdy: got %b want 1", rdy4);
        end
        tick();
        v4 = 1'b0;
        tests++;
        if (ovld4[2] !== 1'b1 || odata4[8:6] !== 3'd6) begin
            fails++;
            $display("FAIL stall_refill: vld2=%b data=%0d want 1/6", ovld4[2], odata4[8:6]);
        end
        tick();
        tests++;
        if (ovld4 !== 4'b0) begin
            fails++;
            $display("FAIL stall_drain: vld=%b want 0000", ovld4);
        end
    endtask

    task automatic test_hol();
        ordy4 = 4'b1101;
        v4 = 1'b1; sel4 = 2'd1; data4 = 3'd3;
        tick();
        data4 = 3'd4;
        for (int c = 0; c < 2; c++) begin
            #1;
            tests++;
            if (rdy4 !== 1'b0 || ovld4 !== 4'b0010) begin
                fails++;
                $display("FAIL hol_block c=%0d: rdy=%b vld=%b want 0/0010", c, rdy4, ovld4);
            end
            tick();
        end
        ordy4[1] = 1'b1;
        tick();
        tests++;
        if (ovld4 !== 4'b0010 || odata4[5:3] !== 3'd4) begin
            fails++;
            $display("FAIL hol_ch1: vld=%b data=%0d want 0010/4", ovld4, odata4[5:3]);
        end
        sel4 = 2'd0; data4 = 3'd2;
        #1;
        tests++;
        if (rdy4 !== 1'b1) begin
            fails++;
            $display("FAIL hol_rdy0: got %b want 1", rdy4);
        end
        tick();
        v4 = 1'b0;
        tests++;
        if (ovld4 !== 4'b0001 || odata4[2:0] !== 3'd2) begin
            fails++;
            $display("FAIL hol_ch0: vld=%b data=%0d want 0001/2", ovld4, odata4[2:0]);
        end
        ordy4 = 4'hF;
        tick();
    endtask

    task automatic test_drop();
        ordy3 = 3'b111;
        v3 = 1'b1; sel3 = 2'd3; data3 = 3'd7;
        #1;
        tests++;
        if (rdy3 !== 1'b1) begin
            fails++;
            $display("FAIL drop_rdy: got %b want 1", rdy3);
        end
        tick();
        tests++;
        if (ovld3 !== 3'b0 || dp3 !== 1'b1 || dc3 !== 4'd1) begin
            fails++;
            $display("FAIL drop_one: vld=%b dp=%b cnt=%0d want 000/1/1", ovld3, dp3, dc3);
        end
        for (int k = 0; k < 20; k++) tick();
        v3 = 1'b0;
        tests++;
        if (dc3 !== 4'd15 || dp3 !== 1'b1) begin
            fails++;
            $display("FAIL drop_sat: cnt=%0d dp=%b want 15/1", dc3, dp3);
        end
        tick();
        tests++;
        if (dc3 !== 4'd15 || dp3 !== 1'b0 || ovld3 !== 3'b0) begin
            fails++;
            $display("FAIL drop_idle: cnt=%0d dp=%b vld=%b want 15/0/000", dc3, dp3, ovld3);
        end
    endtask

    task automatic test_reset_mid();
        ordy4 = 4'b0;
        v4 = 1'b1; sel4 = 2'd0; data4 = 3'd1;
        tick();
        sel4 = 2'd3; data4 = 3'd2;
        tick();
        tests++;
        if (ovld4 !== 4'b1001) begin
            fails++;
            $display("FAIL rmid_setup: vld=%b want 1001", ovld4);
        end
        sel4 = 2'd1; data4 = 3'd6;
        v3 = 1'b1; sel3 = 2'd3;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        v4 = 1'b0; v3 = 1'b0;
        tests++;
        if (ovld4 !== 4'b0 || dc4 !== 4'd0 || dc3 !== 4'd0 || dp3 !== 1'b0) begin
            fails++;
            $display("FAIL rmid_clear: vld4=%b cnt4=%0d cnt3=%0d dp3=%b want 0", ovld4, dc4, dc3, dp3);
        end
        tick();
        tests++;
        if (ovld4 !== 4'b0 || dc3 !== 4'd0 || dp3 !== 1'b0) begin
            fails++;
            $display("FAIL rmid_noaccept: vld4=%b cnt3=%0d dp3=%b want 0", ovld4, dc3, dp3);
        end
        ordy4 = 4'hF;
    endtask

    task automatic test_random();
        logic [2:0] mfull;
        logic [2:0] want;
        logic       exp_rdy, exp_dp, fire;
        int         drops, acc, cyc, s;
        mfull = '0; drops = 0; acc = 0; cyc = 0;
        v3 = 1'b0;
        while (acc < 1000 && cyc < 20000) begin
            cyc++;
            if (!v3) begin
                v3 = ($urandom_range(0, 4) != 0);
                sel3 = 2'($urandom_range(0, 3));
                data3 = 3'($urandom);
            end
            for (int i = 0; i < 3; i++) ordy3[i] = ($urandom_range(0, 3) != 0);
            #1;
            s = int'(sel3);
            exp_rdy = (s == 3) ? 1'b1 : (!mfull[s] || ordy3[s]);
            tests++;
            if (rdy3 !== exp_rdy) begin
                fails++;
                $display("FAIL rand_rdy cyc=%0d: got %b want %b", cyc, rdy3, exp_rdy);
            end
            for (int i = 0; i < 3; i++) begin
                if (mfull[i] && ordy3[i]) begin
                    tests++;
                    if (sbq[i].size() == 0) begin
                        fails++;
                        $display("FAIL rand_extra ch=%0d cyc=%0d: word with empty scoreboard", i, cyc);
                    end else begin
                        want = sbq[i].pop_front();
                        if (odata3[i*3 +: 3] !== want) begin
                            fails++;
                            $display("FAIL rand_data ch=%0d cyc=%0d: got %0d want %0d",
                                     i, cyc, odata3[i*3 +: 3], want);
                        end
                    end
                    mfull[i] = 1'b0;
                end
            end
            fire = v3 && exp_rdy;
            exp_dp = 1'b0;
            if (fire) begin
                acc++;
                if (s == 3) begin
                    drops++;
                    exp_dp = 1'b1;
                end else begin
                    mfull[s] = 1'b1;
                    sbq[s].push_back(data3);
                end
            end
            tick();
            tests++;
            if (ovld3 !== mfull || dp3 !== exp_dp || dc3 !== 4'((drops > 15) ? 15 : drops)) begin
                fails++;
                $display("FAIL rand_state cyc=%0d: vld=%b dp=%b cnt=%0d want %b/%b/%0d",
                         cyc, ovld3, dp3, dc3, mfull, exp_dp, (drops > 15) ? 15 : drops);
            end
            if (fire) v3 = 1'b0;
        end
        tests++;
        if (acc < 1000) begin
            fails++;
            $display("FAIL rand_timeout: accepted %0d want 1000", acc);
        end
        v3 = 1'b0;
        ordy3 = 3'b111;
        #1;
        for (int i = 0; i < 3; i++) begin
            if (mfull[i] && sbq[i].size() != 0) begin
                want = sbq[i].pop_front();
                tests++;
                if (odata3[i*3 +: 3] !== want) begin
                    fails++;
                    $display("FAIL rand_tail ch=%0d: got %0d want %0d", i, odata3[i*3 +: 3], want);
                end
            end
        end
        tick();
        tests++;
        if (ovld3 !== 3'b0 || sbq[0].size() != 0 || sbq[1].size() != 0 || sbq[2].size() != 0) begin
            fails++;
            $display("FAIL rand_loss: vld=%b pending=%0d/%0d/%0d want none",
                     ovld3, sbq[0].size(), sbq[1].size(), sbq[2].size());
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_hol();
        test_drop();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/case_demux.md
Name: case_demux

Overview:
- Registered 1-to-N demultiplexer; the inverse of the case-statement mux used throughout the case-synthesis tests.
- Accepts one valid/ready input stream tagged with a select code.
- Routes each word to exactly one of N output channels, each backed by a one-entry holding register.
- Out-of-range select codes are dropped and counted.
- Sits between a shared producer and N independent consumers.

Parameters:
- N, 4, number of output channels (2..2**SEL_W).
- SEL_W, 2, select code width.
- DATA_W, 3, payload width.
- CNT_W, 4, drop counter width (saturating).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input word present.
- in_ready  out  1  input word accepted this cycle when in_valid & in_ready.
- in_sel  in  SEL_W  destination channel code.
- in_data  in  DATA_W  payload.
- out_valid  out  N  per-channel word present.
- out_ready  in  N  per-channel consumer accept.
- out_data  out  N*DATA_W  channel i payload at bits [i*DATA_W +: DATA_W].
- drop_pulse  out  1  one-cycle pulse, registered, when an out-of-range word was consumed.
- drop_count  out  CNT_W  saturating count of dropped words.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, and named reset.
- Reset values: out_valid=0, out_data=0, drop_pulse=0, drop_count=0. in_ready is combinational and follows the rule below.
- Channel state: each channel has two states, EMPTY (out_valid[i]=0) and FULL (out_valid[i]=1).
  - EMPTY -> FULL on accept of a word with in_sel==i.
  - FULL -> EMPTY on out_ready[i] with no new word for i in the same cycle.
  - FULL stays FULL on simultaneous drain and fill; out_data[i] takes the new word.
- Decode: in_sel is decoded by a case with one item per channel 0..N-1 and a default item that marks the word as a drop. Exactly one target or drop per word.
- in_ready (combinational):
  - Valid target i: in_ready = !out_valid[i] | out_ready[i].
  - Drop target: in_ready = 1.
  - in_ready does not depend on in_valid.
- Latency: a word accepted in cycle t appears on out_valid/out_data at t+1. Full throughput of one word per cycle is possible when consumers keep ready high.
- Ordering: the input is in order, so a stall on one channel blocks all later words (head-of-line). No reordering.
- Drops: when a drop-target word is accepted, drop_pulse=1 next cycle and drop_count increments, holding at 2**CNT_W-1 once saturated.
- out_data[i] holds its value while FULL and not drained. Its value while EMPTY is don't-care, but the implementation keeps the last value.
- Undriven inputs: X or Z on in_sel while in_valid=0 has no effect on state.
- Reset mid-operation: all FULL channels return to EMPTY and held words are lost. A word presented in the reset cycle is not accepted; in_ready may read 1, but state does not change.
- No combinational path from out_ready to out_valid. One path exists from out_ready and in_sel to in_ready.

Decomposition:
- Package case_demux_pkg holds:
  - the channel-state enum (CH_EMPTY, CH_FULL);
  - a function sel_in_range(sel, N);
  - the default parameter constants.
- Sub-module demux_slot implements one channel's holding register and state, and is instantiated N times via generate.
- The top level contains the case decode, in_ready mux and drop counter.

Test Plan:
- Reset, then in_sel=0..3 with in_data=0..3 on consecutive cycles, all out_ready=1 -> out_valid[k] pulses at cycle k+1 with data k. in_ready stays 1 and drop_count=0.
- out_ready[2]=0, send sel=2/data=5, then sel=2/data=6 -> first word held on ch2. in_ready=0 while the second word waits. Raising out_ready[2] drains 5 and loads 6 in the same cycle, so out_valid[2] stays 1 with data 6.
- Head-of-line blocking: ch1 FULL and stalled, input sel=1 then sel=0 -> the ch0 word is not delivered until ch1 drains. After ch1 drains, ch0 receives its word the cycle after acceptance.
- N=3: send sel=3/data=7 -> in_ready=1, no out_valid asserted, drop_pulse=1 one cycle later, drop_count=1. Send 20 more -> drop_count saturates at 15.
- Reset while ch0 and ch3 are FULL and in_valid=1 -> next cycle out_valid=0, drop_count=0, and no word accepted in the reset cycle.
- Random stimulus: 1000 words with random sel and ready patterns -> per-channel scoreboard shows no loss, duplication or reorder within a channel, and drop count matches the number of out-of-range words.
